// File: rtl/sale_transaction_engine.sv
// sale_transaction_engine
//   Transaction core for the sale terminal. Resolves operator commands
//   (barcode digits, direct select, quantity, remove, checkout, clear,
//   cancel) into product IDs. It prices each product from a loadable price
//   table and keeps a bounded basket with a saturating running total.
//
// Ports
//   CLOCK_50      system clock
//   RESET         synchronous active-high reset
//   cmd_valid     command strobe; accepted when cmd_valid & cmd_ready
//   cmd_code      0 DIGIT, 1 SELECT, 2 QTY, 3 REMOVE, 4 CHECKOUT,
//                 5 CLEAR, 6 CANCEL, 7 reserved
//   cmd_data      digit / product ID / quantity payload
//   cmd_ready     low only while a line is being added
//   price_we      price table write enable (any state)
//   price_addr    price table address
//   price_data    price written
//   state         0 IDLE, 1 ENTRY, 2 QTY, 3 ADD, 4 CHECKOUT
//   digit_count   barcode digits entered so far
//   barcode_flat  entered digits, digit 0 at the LSBs
//   sel_id        currently selected product
//   highlight     one-hot of sel_id while in QTY/ADD
//   basket_count  number of basket lines
//   total         running total
//   err           one-cycle pulse on a rejected command
//   add_done      one-cycle pulse when a line is appended
module sale_transaction_engine #(
  parameter int DIGITS       = 4,
  parameter int PRODUCTS     = 12,
  parameter int BASKET_DEPTH = 8,
  parameter int QTY_W        = 4,
  parameter int PRICE_W      = 10,
  parameter int TOTAL_W      = 16,
  localparam int ID_W        = $clog2(PRODUCTS),
  localparam int CNT_W       = $clog2(BASKET_DEPTH + 1)
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd_code,
  input  logic [3:0]          cmd_data,
  output logic                cmd_ready,
  input  logic                price_we,
  input  logic [ID_W-1:0]     price_addr,
  input  logic [PRICE_W-1:0]  price_data,
  output logic [2:0]          state,
  output logic [2:0]          digit_count,
  output logic [4*DIGITS-1:0] barcode_flat,
  output logic [ID_W-1:0]     sel_id,
  output logic [PRODUCTS-1:0] highlight,
  output logic [CNT_W-1:0]    basket_count,
  output logic [TOTAL_W-1:0]  total,
  output logic                err,
  output logic                add_done
);

  localparam int LINE_W = PRICE_W + QTY_W;
  localparam int IDX_W  = $clog2(BASKET_DEPTH);
  localparam int SUM_W  = ((TOTAL_W > LINE_W) ? TOTAL_W : LINE_W) + 1;
  localparam int BC_W   = 4 * DIGITS;

  localparam logic [2:0] C_DIGIT    = 3'd0;
  localparam logic [2:0] C_SELECT   = 3'd1;
  localparam logic [2:0] C_QTY      = 3'd2;
  localparam logic [2:0] C_REMOVE   = 3'd3;
  localparam logic [2:0] C_CHECKOUT = 3'd4;
  localparam logic [2:0] C_CLEAR    = 3'd5;
  localparam logic [2:0] C_CANCEL   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_QTY      = 3'd2,
    S_ADD      = 3'd3,
    S_CHECKOUT = 3'd4
  } state_t;

  // Saturating add; MSB of the result flags that saturation occurred.
  function automatic logic [TOTAL_W:0] sat_add(input logic [TOTAL_W-1:0] a,
                                               input logic [LINE_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({TOTAL_W{1'b1}})) sat_add = {1'b1, {TOTAL_W{1'b1}}};
    else                             sat_add = {1'b0, s[TOTAL_W-1:0]};
  endfunction

  // Subtract with floor at zero (total may have been clipped by sat_add).
  function automatic logic [TOTAL_W-1:0] floor_sub(input logic [TOTAL_W-1:0] a,
                                                   input logic [LINE_W-1:0]  b);
    if (SUM_W'(b) >= SUM_W'(a)) floor_sub = '0;
    else                        floor_sub = TOTAL_W'(SUM_W'(a) - SUM_W'(b));
  endfunction

  state_t                    r_state, w_state;
  logic [2:0]                r_digit_count, w_digit_count;
  logic [BC_W-1:0]           r_barcode, w_barcode, w_bc_new;
  logic [ID_W-1:0]           r_sel_id, w_sel_id;
  logic [QTY_W-1:0]          r_qty, w_qty;
  logic [CNT_W-1:0]          r_count, w_count;
  logic [TOTAL_W-1:0]        r_total, w_total;
  logic                      r_err, w_err;
  logic                      r_add_done, w_add_done;
  logic                      w_push;
  logic [31:0]               w_value;
  logic                      w_last;
  logic                      w_full;
  logic [LINE_W-1:0]         w_line;
  logic [LINE_W-1:0]         w_pop_line;
  logic [TOTAL_W:0]          w_sum;
  logic [TOTAL_W-1:0]        w_sub;
  logic [IDX_W-1:0]          w_wr_idx, w_rd_idx;

  // Price table and basket storage carry no reset; basket validity is r_count.
  logic [PRICE_W-1:0]        r_price  [PRODUCTS];
  logic [ID_W+LINE_W-1:0]    r_basket [BASKET_DEPTH];

  assign w_full     = (r_count == CNT_W'(BASKET_DEPTH));
  assign w_wr_idx   = IDX_W'(r_count);
  assign w_rd_idx   = IDX_W'(r_count - CNT_W'(1));
  // Read sees the table before any write on this same edge, so a write to
  // sel_id during ADD only affects later lines.
  assign w_line     = LINE_W'(r_price[r_sel_id]) * LINE_W'(r_qty);
  assign w_pop_line = r_basket[w_rd_idx][LINE_W-1:0];
  assign w_sum      = sat_add(r_total, w_line);
  assign w_sub      = floor_sub(r_total, w_pop_line);
  assign w_last     = (r_digit_count == 3'(DIGITS - 1));

  // Barcode with the incoming digit placed, and its decimal value (digit 0 most significant).
  always_comb begin
    w_bc_new = r_barcode;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == int'(r_digit_count)) w_bc_new[4*i +: 4] = cmd_data;
    end
    w_value = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_value = w_value * 32'd10 + 32'(w_bc_new[4*i +: 4]);
    end
  end

  always_comb begin
    w_state       = r_state;
    w_digit_count = r_digit_count;
    w_barcode     = r_barcode;
    w_sel_id      = r_sel_id;
    w_qty         = r_qty;
    w_count       = r_count;
    w_total       = r_total;
    w_err         = 1'b0;
    w_add_done    = 1'b0;
    w_push        = 1'b0;
    if (r_state == S_ADD) begin
      // Commands are not accepted here; cmd_ready is low.
      if (w_full) begin
        w_err = 1'b1;
      end else begin
        w_push     = 1'b1;
        w_count    = r_count + CNT_W'(1);
        w_total    = w_sum[TOTAL_W-1:0];
        w_err      = w_sum[TOTAL_W];
        w_add_done = 1'b1;
      end
      w_state       = S_IDLE;
      w_digit_count = '0;
      w_barcode     = '0;
    end else if (cmd_valid) begin
      case (cmd_code)
        C_DIGIT: begin
          if ((r_state == S_IDLE || r_state == S_ENTRY) && cmd_data <= 4'd9) begin
            if (w_last && w_value >= 32'(PRODUCTS)) begin
              w_err         = 1'b1;
              w_barcode     = '0;
              w_digit_count = '0;
              w_state       = S_IDLE;
            end else begin
              w_barcode     = w_bc_new;
              w_digit_count = r_digit_count + 3'd1;
              if (w_last) begin
                w_sel_id = ID_W'(w_value);
                w_state  = S_QTY;
              end else begin
                w_state  = S_ENTRY;
              end
            end
          end else begin
            w_err = 1'b1;
          end
        end
        C_SELECT: begin
          if (r_state == S_IDLE && 32'(cmd_data) < 32'(PRODUCTS)) begin
            w_sel_id = ID_W'(cmd_data);
            w_state  = S_QTY;
          end else begin
            w_err = 1'b1;
          end
        end
        C_QTY: begin
          if (r_state == S_QTY && cmd_data != 4'd0) begin
            w_qty   = QTY_W'(cmd_data);
            w_state = S_ADD;
          end else begin
            w_err = 1'b1;
          end
        end
        C_REMOVE: begin
          if (r_state == S_IDLE && r_count != '0) begin
            w_count = r_count - CNT_W'(1);
            w_total = w_sub;
          end else begin
            w_err = 1'b1;
          end
        end
        C_CHECKOUT: begin
          if (r_state == S_IDLE && r_count != '0) w_state = S_CHECKOUT;
          else                                    w_err   = 1'b1;
        end
        C_CLEAR: begin
          if (r_state == S_CHECKOUT) begin
            w_count = '0;
            w_total = '0;
            w_state = S_IDLE;
          end else begin
            w_err = 1'b1;
          end
        end
        C_CANCEL: begin
          if (r_state == S_ENTRY || r_state == S_QTY) begin
            w_digit_count = '0;
            w_barcode     = '0;
            w_sel_id      = '0;
            w_state       = S_IDLE;
          end else if (r_state != S_IDLE) begin
            w_err = 1'b1;
          end
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_digit_count <= '0;
      r_barcode     <= '0;
      r_sel_id      <= '0;
      r_qty         <= '0;
      r_count       <= '0;
      r_total       <= '0;
      r_err         <= 1'b0;
      r_add_done    <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_digit_count <= w_digit_count;
      r_barcode     <= w_barcode;
      r_sel_id      <= w_sel_id;
      r_qty         <= w_qty;
      r_count       <= w_count;
      r_total       <= w_total;
      r_err         <= w_err;
      r_add_done    <= w_add_done;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (price_we && 32'(price_addr) < 32'(PRODUCTS)) r_price[price_addr] <= price_data;
    if (w_push && !RESET) r_basket[w_wr_idx] <= {r_sel_id, w_line};
  end

  assign cmd_ready    = (r_state != S_ADD);
  assign state        = r_state;
  assign digit_count  = r_digit_count;
  assign barcode_flat = r_barcode;
  assign sel_id       = r_sel_id;
  assign highlight    = (r_state == S_QTY || r_state == S_ADD) ?
                        (PRODUCTS'(1) << r_sel_id) : '0;
  assign basket_count = r_count;
  assign total        = r_total;
  assign err          = r_err;
  assign add_done     = r_add_done;

endmodule
